lfsr_msg_encryptor: RTL

Hardware encryptor for the 64-byte LFSR message-cipher format; it is the transmit end whose output the decryption program consumes.
- Takes an ASCII message stream plus configuration: tap pattern, seed, preamble length.
- Emits exactly 64 cipher bytes, each parity-tagged, on a valid/ready stream.
- Sits beside the processor data path. Used to fill data memory 64..127, and as a golden source for decrypt regression.

---
 rtl/lfsr_msg_encryptor_pkg.sv | 47 ++++
 rtl/lfsr_msg_encryptor_lfsr7_step.sv | 20 ++
 rtl/lfsr_msg_encryptor.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_msg_encryptor_pkg.sv
// enc_pkg: shared types, frame constants and config helpers for the
// 64-byte LFSR message encryptor and its verification models.
package enc_pkg;

    localparam int NBYTES  = 64;
    localparam int MIN_PRE = 10;
    localparam int MAX_MSG = 52;
    localparam logic [7:0] ASCII_BIAS = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        MSG,
        POST,
        DONE
    } enc_state_t;

    // The nine maximal-length tap masks; index 0 is 7'h60.
    localparam int NUM_TAPS = 9;
    localparam logic [8:0][6:0] LEGAL_TAPS = {
        7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
    };

    // Preamble requests below the minimum are raised to it.
    function automatic logic [5:0] eff_pre(input logic [5:0] req);
        if (req < 6'(MIN_PRE)) begin
            return 6'(MIN_PRE);
        end
        return req;
    endfunction

    // Message length clipped to the character limit and to the room left after the preamble.
    function automatic logic [5:0] eff_len(input logic [5:0] req, input logic [5:0] pre);
        logic [6:0] room;
        logic [6:0] len;
        room = 7'(NBYTES) - {1'b0, pre};
        len  = {1'b0, req};
        if (len > 7'(MAX_MSG)) begin
            len = 7'(MAX_MSG);
        end
        if (len > room) begin
            len = room;
        end
        return len[5:0];
    endfunction

endpackage

// File: rtl/lfsr_msg_encryptor_lfsr7_step.sv
// lfsr7_step: one step of the 7-bit Fibonacci LFSR plus the parity-tagged
// cipher byte formed from the current state and a 7-bit plaintext.
module lfsr7_step (
    input  logic [6:0] state,
    input  logic [6:0] taps,
    input  logic [6:0] plain,
    output logic [6:0] next_state,
    output logic [7:0] cipher
);

    logic [6:0] masked;

    // Shift left, feed back the parity of the tapped bits, and tag the cipher with even-ones parity.
    always_comb begin
        next_state  = {state[5:0], ^(state & taps)};
        masked      = plain ^ state;
        cipher      = {^masked, masked};
    end

endmodule

// File: rtl/lfsr_msg_encryptor.sv
// lfsr_msg_encryptor: streams one 64-byte cipher frame (preamble, message,
// postamble) through a single-entry valid/ready output register.
// Optional macro ENC_LFSR_DBG_EN adds the lfsr_dbg output showing the LFSR
// state that produced the byte currently on out_data.
module lfsr_msg_encryptor
    import enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] tap_ptrn,
    input  logic [6:0] lfsr_init,
    input  logic [5:0] pre_len,
    input  logic [5:0] msg_len,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       ack
`ifdef ENC_LFSR_DBG_EN
    ,
    output logic [6:0] lfsr_dbg
`endif
);

    enc_state_t state, state_nxt;

    logic [6:0] lfsr;
    logic [6:0] taps_q;
    logic [5:0] idx;
    logic [5:0] pre_q;
    logic [5:0] len_q;
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic       ack_q;

    logic       can_load;
    logic       load;
    logic       ack_set;
    logic [6:0] plain;
    logic [6:0] msg_plain;
    logic [6:0] step_next;
    logic [7:0] step_cipher;
    logic [6:0] msg_end;
    logic       last_pre;
    logic       last_msg;
    logic       last_byte;
    logic [5:0] cfg_pre;
    logic       in_data_msb_unused;

    // The bias only touches the low seven bits that survive into the cipher.
    assign msg_plain          = in_data[6:0] - ASCII_BIAS[6:0];
    assign in_data_msb_unused = in_data[7];

    assign can_load  = !out_valid_q || out_ready;
    assign msg_end   = {1'b0, pre_q} + {1'b0, len_q} - 7'd1;
    assign last_pre  = (idx == pre_q - 6'd1);
    assign last_msg  = ({1'b0, idx} == msg_end);
    assign last_byte = (idx == 6'(NBYTES - 1));
    assign cfg_pre   = eff_pre(pre_len);

    lfsr7_step u_step (
        .state      (lfsr),
        .taps       (taps_q),
        .plain      (plain),
        .next_state (step_next),
        .cipher     (step_cipher)
    );

    // State register; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: decides when a byte loads, what plaintext it carries, and the next phase.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ack_set   = 1'b0;
        plain     = 7'h00;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PRE;
                end
            end
            PRE: begin
                if (can_load) begin
                    load = 1'b1;
                    if (last_pre) begin
                        state_nxt = (len_q == 6'd0) ? POST : MSG;
                    end
                end
            end
            MSG: begin
                in_ready = can_load;
                if (in_valid && can_load) begin
                    load  = 1'b1;
                    plain = msg_plain;
                    if (last_msg) begin
                        state_nxt = last_byte ? DONE : POST;
                    end
                end
            end
            POST: begin
                if (can_load) begin
                    load = 1'b1;
                    if (last_byte) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (can_load) begin
                    ack_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Config latch on start, LFSR/index advance per loaded byte, and the output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr        <= 7'h01;
            taps_q      <= 7'h00;
            idx         <= 6'd0;
            pre_q       <= 6'd0;
            len_q       <= 6'd0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= ack_set;
            if (state == IDLE && start) begin
                taps_q <= tap_ptrn;
                lfsr   <= (lfsr_init == 7'h00) ? 7'h01 : lfsr_init;
                idx    <= 6'd0;
                pre_q  <= cfg_pre;
                len_q  <= eff_len(msg_len, cfg_pre);
            end
            if (load) begin
                out_data_q  <= step_cipher;
                out_valid_q <= 1'b1;
                lfsr        <= step_next;
                idx         <= idx + 6'd1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef ENC_LFSR_DBG_EN
    logic [6:0] lfsr_dbg_q;

    // Remember which LFSR state formed the byte now sitting in the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_dbg_q <= 7'h00;
        end else if (load) begin
            lfsr_dbg_q <= lfsr;
        end
    end

    assign lfsr_dbg = lfsr_dbg_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state != IDLE);
    assign ack       = ack_q;

endmodule
